// File: rtl/myproject_sdiv_31s_17s_16_seq.sv
// Sequential signed restoring divider: one quotient bit per cycle,
// saturating quotient, remainder signed like the dividend.
module myproject_sdiv_31s_17s_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 31,
  parameter int din1_WIDTH = 17,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int WQ = dout_WIDTH;
  localparam int CW = $clog2(W0 + 1);

  localparam logic [WQ-1:0] DMAX = {1'b0, {(WQ-1){1'b1}}};
  localparam logic [WQ-1:0] DMIN = {1'b1, {(WQ-1){1'b0}}};
  localparam logic [W0-1:0] QLIM = {{(W0-WQ){1'b0}}, DMAX};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W0-1:0] q;
  logic [W1:0]   r;
  logic [W1-1:0] d;
  logic          s0;
  logic          s1;

  logic [W0-1:0] mag0;
  logic [W1-1:0] mag1;
  logic [W1:0]   shifted;
  logic [W1+1:0] diff;
  logic          fit;
  logic          neg;

  // Unsigned magnitudes keep -2^(W-1) exact because the result is W bits unsigned
  always_comb begin
    mag0    = din0[W0-1] ? -din0 : din0;
    mag1    = din1[W1-1] ? -din1 : din1;
    shifted = {r[W1-1:0], q[W0-1]};
    diff    = {1'b0, shifted} - {2'b0, d};
    fit     = !diff[W1+1];
    neg     = s0 ^ s1;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      dout  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q     <= mag0;
            d     <= mag1;
            r     <= '0;
            s0    <= din0[W0-1];
            s1    <= din1[W1-1];
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == CW'(W0)) begin
            state <= DONE;
            if (d == '0) begin
              dbz  <= 1'b1;
              ovf  <= 1'b0;
              rem  <= '0;
              dout <= s0 ? DMIN : DMAX;
            end else begin
              dbz <= 1'b0;
              rem <= s0 ? W1'(-r) : W1'(r);
              if (!neg && q > QLIM) begin
                dout <= DMAX;
                ovf  <= 1'b1;
              end else if (neg && q > QLIM + W0'(1)) begin
                dout <= DMIN;
                ovf  <= 1'b1;
              end else begin
                dout <= neg ? -q[WQ-1:0] : q[WQ-1:0];
                ovf  <= 1'b0;
              end
            end
          end else begin
            r   <= fit ? diff[W1:0] : shifted;
            q   <= {q[W0-2:0], fit};
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_31s_17s_16_seq.sv
// Randomised bench for the sequential signed divider against an
// arithmetic reference model with cycle-exact handshake checks.
module tb_myproject_sdiv_31s_17s_16_seq;

  logic        clk;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] din0;
  logic [16:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic [16:0] rem;
  logic        ovf;
  logic        dbz;

  typedef struct packed {
    logic [15:0] q;
    logic [16:0] r;
    logic        o;
    logic        z;
  } res_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  bit   pending = 0;
  bit   rst_prev = 0;
  res_t cur;

  myproject_sdiv_31s_17s_16_seq dut (
    .ap_clk   (clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero
  function automatic res_t model(input longint a, input longint b);
    res_t   e;
    longint qt;
    e.o = 1'b0;
    if (b == 0) begin
      e.z = 1'b1;
      e.r = '0;
      e.q = (a >= 0) ? 16'h7fff : 16'h8000;
    end else begin
      e.z = 1'b0;
      qt  = a / b;
      e.r = 17'(a % b);
      if (qt > 32767) begin
        e.q = 16'h7fff;
        e.o = 1'b1;
      end else if (qt < -32768) begin
        e.q = 16'h8000;
        e.o = 1'b1;
      end else begin
        e.q = 16'(qt);
      end
    end
    return e;
  endfunction

  task automatic pin(input longint a, input longint b, input longint q,
                     input longint r, input bit o, input bit z);
    res_t e;
    e = model(a, b);
    chk("pin_q", longint'($signed(e.q)), q);
    chk("pin_r", longint'($signed(e.r)), r);
    chk("pin_ovf", {63'd0, e.o}, {63'd0, o});
    chk("pin_dbz", {63'd0, e.z}, {63'd0, z});
  endtask

  // Compare process: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    bit exp_ov;
    if (rst_prev) begin
      chk("rst_dout", {48'd0, dout}, 0);
      chk("rst_rem", {47'd0, rem}, 0);
      chk("rst_ovf", {63'd0, ovf}, 0);
      chk("rst_dbz", {63'd0, dbz}, 0);
    end
    exp_ov = pending && (cyc >= hs_cyc + 32);
    chk("in_ready", {63'd0, in_ready}, {63'd0, !pending});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    if (exp_ov && out_valid) begin
      chk("dout", longint'($signed(dout)), longint'($signed(cur.q)));
      chk("rem", longint'($signed(rem)), longint'($signed(cur.r)));
      chk("ovf", {63'd0, ovf}, {63'd0, cur.o});
      chk("dbz", {63'd0, dbz}, {63'd0, cur.z});
    end
    if (ap_rst) begin
      pending = 0;
    end else if (!pending && in_valid) begin
      pending = 1;
      hs_cyc  = cyc + 1;
      cur     = model(longint'($signed(din0)), longint'($signed(din1)));
    end else if (exp_ov && out_ready) begin
      pending = 0;
    end
    rst_prev = ap_rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input longint a, input longint b, input int hold,
                     input bit do_rst);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    din0     = a[30:0];
    din1     = b[16:0];
    step();
    for (int k = 1; k < 30; k++) begin
      if (do_rst && k == 15) begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ap_rst    = 1'b1;
        step();
        ap_rst = 1'b0;
        return;
      end
      in_valid  = 1'($urandom);
      din0      = 31'($urandom);
      din1      = 17'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    repeat (hold) begin
      in_valid = 1'($urandom);
      din0     = 31'($urandom);
      din1     = 17'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic longint rnd_a();
    logic signed [30:0] t;
    t = 31'($urandom);
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 200000)) - 100000;
      1: return ($urandom_range(0, 1) != 0) ? -1073741824 : 1073741823;
      2: return longint'($urandom_range(0, 40)) - 20;
      default: return longint'(t);
    endcase
  endfunction

  function automatic longint rnd_b();
    logic signed [16:0] t;
    t = 17'($urandom);
    case ($urandom_range(0, 4))
      0: return 0;
      1: return longint'($urandom_range(0, 40)) - 20;
      2: begin
        case ($urandom_range(0, 3))
          0: return -65536;
          1: return 65535;
          2: return 1;
          default: return -1;
        endcase
      end
      default: return longint'(t);
    endcase
  endfunction

  initial begin
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;

    pin(1000, 7, 142, 6, 0, 0);
    pin(-1000, 7, -142, -6, 0, 0);
    pin(1000, -7, -142, 6, 0, 0);
    pin(1000, 0, 32767, 0, 0, 1);
    pin(-5, 0, -32768, 0, 0, 1);
    pin(-1073741824, -1, 32767, 0, 1, 0);
    pin(-1073741824, 1, -32768, 0, 1, 0);
    pin(65535, 2, 32767, 1, 0, 0);
    pin(100, 3, 33, 1, 0, 0);

    repeat (3) step();
    ap_rst = 1'b0;
    step();

    run(1000, 7, 0, 0);
    run(-1000, 7, 2, 0);
    run(1000, -7, 0, 0);
    run(1000, 0, 1, 0);
    run(-5, 0, 0, 0);
    run(-1073741824, -1, 0, 0);
    run(-1073741824, 1, 0, 0);
    run(65535, 2, 10, 0);
    run(-1073741824, -65536, 0, 0);
    run(1000, 7, 0, 1);
    run(100, 3, 0, 0);

    for (int i = 0; i < 40; i++)
      run(rnd_a(), rnd_b(), $urandom_range(0, 3), 0);

    repeat (5) step();
    chk("drained", {63'd0, pending}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
